// File: rtl/audio_pkt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : audio_pkt_pkg
// Purpose  : shared state encoding and constants for the audio packet reader
// Revision : 1.0 - initial release
// ============================================================================
package audio_pkt_pkg;

   localparam int          SEQ_WIDTH         = 16;
   localparam logic [15:0] DEFAULT_HDR_MAGIC = 16'hA55A;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_DATA = 2'd2,
      ST_TRL  = 2'd3
   } state_e;

endpackage
`default_nettype wire

// File: rtl/audio_pkt_csum.sv
`default_nettype none
// ============================================================================
// Module   : audio_pkt_csum
// Purpose  : modulo-2^DATA_WIDTH payload accumulator, clear has priority over add
// Revision : 1.0 - initial release
// ============================================================================
module audio_pkt_csum #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clr_i,
   input  logic                  add_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic [DATA_WIDTH-1:0] sum_o
);

   logic [DATA_WIDTH-1:0] acc_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         acc_q <= '0;
      end else if (add_i) begin
         acc_q <= acc_q + data_i;
      end
   end

   assign sum_o = acc_q;

endmodule
`default_nettype wire

// File: rtl/audio_pkt_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module   : audio_pkt_fifo_reader
// Purpose  : drains PKT_LEN show-ahead FIFO words as a framed valid/ready stream
// Options  : AUDIO_PKT_CHECKSUM_EN adds a checksum trailer word after the payload
// Revision : 1.0 - initial release
// ============================================================================
module audio_pkt_fifo_reader
   import audio_pkt_pkg::*;
#(
   parameter int          DATA_WIDTH = 32,
   parameter int          ADDR_WIDTH = 10,
   parameter int          PKT_LEN    = 256,
   parameter logic [15:0] HDR_MAGIC  = DEFAULT_HDR_MAGIC
) (
   input  logic                  rd_clk,
   input  logic                  rd_rst,
   input  logic                  pkt_en,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   input  logic                  fifo_empty,
   input  logic [ADDR_WIDTH:0]   fifo_rd_water_level,
   output logic                  fifo_rd_en,
   output logic [DATA_WIDTH-1:0] pkt_data,
   output logic                  pkt_valid,
   input  logic                  pkt_ready,
   output logic                  pkt_sop,
   output logic                  pkt_eop,
   output logic [SEQ_WIDTH-1:0]  pkt_seq,
   output logic                  underrun
);

   localparam int                 CNT_W     = $clog2(PKT_LEN + 1);
   localparam logic [CNT_W-1:0]   LAST_IDX  = CNT_W'(PKT_LEN - 1);
   localparam logic [ADDR_WIDTH:0] START_LVL = (ADDR_WIDTH + 1)'(PKT_LEN);

   state_e                 state_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [SEQ_WIDTH-1:0]   seq_q;
   logic                   underrun_q;

   logic start;
   logic hs;
   logic last_word;

   assign start     = pkt_en && (fifo_rd_water_level >= START_LVL);
   assign hs        = pkt_valid & pkt_ready;
   assign last_word = (cnt_q == LAST_IDX);

`ifdef AUDIO_PKT_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] csum;

   audio_pkt_csum #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_csum (
      .clk_i  (rd_clk),
      .rst_i  (rd_rst),
      .clr_i  ((state_q == ST_IDLE) && start),
      .add_i  ((state_q == ST_DATA) && hs),
      .data_i (fifo_rd_data),
      .sum_o  (csum)
   );
`endif

   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         seq_q      <= '0;
         underrun_q <= 1'b0;
      end else begin
         if ((state_q == ST_DATA) && fifo_empty) begin
            underrun_q <= 1'b1;
         end
         case (state_q)
            ST_IDLE: begin
               if (start) state_q <= ST_HDR;
            end
            ST_HDR: begin
               if (hs) begin
                  state_q <= ST_DATA;
                  cnt_q   <= '0;
               end
            end
            ST_DATA: begin
               if (hs) begin
                  if (last_word) begin
                     cnt_q <= '0;
`ifdef AUDIO_PKT_CHECKSUM_EN
                     state_q <= ST_TRL;
`else
                     state_q <= ST_IDLE;
                     seq_q   <= seq_q + SEQ_WIDTH'(1);
`endif
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
`ifdef AUDIO_PKT_CHECKSUM_EN
            ST_TRL: begin
               if (hs) begin
                  state_q <= ST_IDLE;
                  seq_q   <= seq_q + SEQ_WIDTH'(1);
               end
            end
`endif
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // DATA-state outputs follow the show-ahead head word so a pop equals a handshake
   always_comb begin
      pkt_data   = '0;
      pkt_valid  = 1'b0;
      pkt_sop    = 1'b0;
      pkt_eop    = 1'b0;
      fifo_rd_en = 1'b0;
      case (state_q)
         ST_HDR: begin
            pkt_data  = DATA_WIDTH'({HDR_MAGIC, seq_q});
            pkt_valid = 1'b1;
            pkt_sop   = 1'b1;
         end
         ST_DATA: begin
            pkt_data   = fifo_rd_data;
            pkt_valid  = ~fifo_empty;
            fifo_rd_en = pkt_ready & ~fifo_empty;
`ifndef AUDIO_PKT_CHECKSUM_EN
            pkt_eop    = last_word;
`endif
         end
`ifdef AUDIO_PKT_CHECKSUM_EN
         ST_TRL: begin
            pkt_data  = csum;
            pkt_valid = 1'b1;
            pkt_eop   = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   assign pkt_seq  = seq_q;
   assign underrun = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_pkt_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_pkt_fifo_reader
// Purpose  : directed self-checking bench for audio_pkt_fifo_reader, PKT_LEN=4
// Options  : AUDIO_PKT_CHECKSUM_EN switches expectations to the trailer format
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_pkt_fifo_reader;

   localparam int DW = 32;
   localparam int AW = 10;
   localparam int PL = 4;
`ifdef AUDIO_PKT_CHECKSUM_EN
   localparam int PW = PL + 2;
`else
   localparam int PW = PL + 1;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          pkt_en = 1'b0;
   logic          ready = 1'b1;
   logic [DW-1:0] fifo_rd_data;
   logic          fifo_empty;
   logic [AW:0]   level;
   logic          rd_en;
   logic [DW-1:0] pkt_data;
   logic          pkt_valid;
   logic          pkt_sop;
   logic          pkt_eop;
   logic [15:0]   pkt_seq;
   logic          underrun;

   int n_cmp = 0;
   int n_err = 0;

   // show-ahead FIFO model
   logic [DW-1:0] mem [0:1023];
   int wr_ptr = 0;
   int rd_ptr = 0;
   int pops   = 0;

   assign fifo_rd_data = mem[rd_ptr % 1024];
   assign fifo_empty   = (wr_ptr == rd_ptr);
   assign level        = (AW + 1)'(wr_ptr - rd_ptr);

   always @(posedge clk) begin
      if (rd_en) begin
         rd_ptr <= rd_ptr + 1;
         pops   <= pops + 1;
      end
   end

   // handshake log
   logic [DW-1:0] log_data [0:255];
   logic          log_sop  [0:255];
   logic          log_eop  [0:255];
   int n_log = 0;

   always @(posedge clk) begin
      if (pkt_valid && ready) begin
         log_data[n_log % 256] <= pkt_data;
         log_sop[n_log % 256]  <= pkt_sop;
         log_eop[n_log % 256]  <= pkt_eop;
         n_log                 <= n_log + 1;
      end
   end

   logic [DW-1:0] exp_d [0:5];

   always #5 clk = ~clk;

   audio_pkt_fifo_reader #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .PKT_LEN    (PL),
      .HDR_MAGIC  (16'hA55A)
   ) dut (
      .rd_clk              (clk),
      .rd_rst              (rst),
      .pkt_en              (pkt_en),
      .fifo_rd_data        (fifo_rd_data),
      .fifo_empty          (fifo_empty),
      .fifo_rd_water_level (level),
      .fifo_rd_en          (rd_en),
      .pkt_data            (pkt_data),
      .pkt_valid           (pkt_valid),
      .pkt_ready           (ready),
      .pkt_sop             (pkt_sop),
      .pkt_eop             (pkt_eop),
      .pkt_seq             (pkt_seq),
      .underrun            (underrun)
   );

   task automatic push(input logic [DW-1:0] w);
      mem[wr_ptr % 1024] = w;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic set_expect(input logic [DW-1:0] hdr, input logic [DW-1:0] p0,
                             input logic [DW-1:0] p1, input logic [DW-1:0] p2,
                             input logic [DW-1:0] p3);
      exp_d[0] = hdr;
      exp_d[1] = p0;
      exp_d[2] = p1;
      exp_d[3] = p2;
      exp_d[4] = p3;
      exp_d[5] = p0 + p1 + p2 + p3;
   endtask

   task automatic wait_log(input int target, input string name, output int waited);
      waited = 0;
      while (n_log < target && waited < 60) begin
         @(negedge clk);
         waited++;
      end
      if (n_log < target) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s timeout: logged %0d words, required %0d", name, n_log, target);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({pkt_valid, pkt_sop, pkt_eop, rd_en, underrun} !== 5'b0 || pkt_data !== '0 ||
          pkt_seq !== 16'h0) begin
         n_err++;
         $display("FAIL reset: valid/sop/eop/rd_en/underrun=%b data=%h seq=%h, required all zero",
                  {pkt_valid, pkt_sop, pkt_eop, rd_en, underrun}, pkt_data, pkt_seq);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic;
      int base, p0, waited;
      base = n_log;
      p0   = pops;
      set_expect(32'hA55A0000, 32'h11, 32'h22, 32'h33, 32'h44);
      pkt_en = 1'b1;
      ready  = 1'b1;
      push(32'h11); push(32'h22); push(32'h33); push(32'h44);
      @(negedge clk);
      n_cmp++;
      if (pkt_valid !== 1'b1 || pkt_sop !== 1'b1 || pkt_data !== 32'hA55A0000) begin
         n_err++;
         $display("FAIL basic_latency: valid=%b sop=%b data=%h, required 1 1 a55a0000",
                  pkt_valid, pkt_sop, pkt_data);
      end
      wait_log(base + PW, "basic", waited);
      n_cmp++;
      if (waited !== PW) begin
         n_err++;
         $display("FAIL basic_throughput: %0d cycles after header, required %0d", waited, PW);
      end
      for (int k = 0; k < PW; k++) begin
         n_cmp++;
         if (log_data[base+k] !== exp_d[k] || log_sop[base+k] !== (k == 0) ||
             log_eop[base+k] !== (k == PW-1)) begin
            n_err++;
            $display("FAIL basic_word%0d: data=%h sop=%b eop=%b, required %h %b %b", k,
                     log_data[base+k], log_sop[base+k], log_eop[base+k], exp_d[k], k == 0, k == PW-1);
         end
      end
      @(negedge clk);
      n_cmp++;
      if (pops - p0 !== PL || pkt_seq !== 16'd1 || pkt_valid !== 1'b0) begin
         n_err++;
         $display("FAIL basic_end: pops=%0d seq=%h valid=%b, required 4 0001 0", pops - p0,
                  pkt_seq, pkt_valid);
      end
      pkt_en = 1'b0;
   endtask

   task automatic test_below_threshold;
      int base, waited;
      base = n_log;
      set_expect(32'hA55A0001, 32'h01, 32'h02, 32'h03, 32'h04);
      pkt_en = 1'b1;
      push(32'h01); push(32'h02); push(32'h03);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_cmp++;
         if (pkt_valid !== 1'b0 || rd_en !== 1'b0) begin
            n_err++;
            $display("FAIL below_threshold cycle %0d: valid=%b rd_en=%b, required 0 0", c,
                     pkt_valid, rd_en);
         end
      end
      push(32'h04);
      @(negedge clk);
      n_cmp++;
      if (pkt_valid !== 1'b1 || pkt_sop !== 1'b1 || pkt_data !== 32'hA55A0001) begin
         n_err++;
         $display("FAIL threshold_hdr: valid=%b sop=%b data=%h, required 1 1 a55a0001",
                  pkt_valid, pkt_sop, pkt_data);
      end
      wait_log(base + PW, "threshold", waited);
      for (int k = 0; k < PW; k++) begin
         n_cmp++;
         if (log_data[base+k] !== exp_d[k] || log_eop[base+k] !== (k == PW-1)) begin
            n_err++;
            $display("FAIL threshold_word%0d: data=%h eop=%b, required %h %b", k,
                     log_data[base+k], log_eop[base+k], exp_d[k], k == PW-1);
         end
      end
      pkt_en = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_backpressure;
      int base, p0;
      logic          s_stall;
      logic [DW-1:0] s_data;
      logic          s_sop, s_eop;
      base    = n_log;
      p0      = pops;
      s_stall = 1'b0;
      set_expect(32'hA55A0002, 32'hA1, 32'hB2, 32'hC3, 32'hD4);
      ready  = 1'b0;
      pkt_en = 1'b1;
      push(32'hA1); push(32'hB2); push(32'hC3); push(32'hD4);
      for (int c = 0; c < 40 && n_log < base + PW; c++) begin
         @(negedge clk);
         if (s_stall) begin
            n_cmp++;
            if (pkt_data !== s_data || pkt_sop !== s_sop || pkt_eop !== s_eop || pkt_valid !== 1'b1) begin
               n_err++;
               $display("FAIL bp_stable cycle %0d: data=%h sop=%b eop=%b valid=%b, required %h %b %b 1",
                        c, pkt_data, pkt_sop, pkt_eop, pkt_valid, s_data, s_sop, s_eop);
            end
         end
         ready = ~ready;
         #1;
         n_cmp++;
         if (!ready && rd_en !== 1'b0) begin
            n_err++;
            $display("FAIL bp_pop cycle %0d: rd_en=%b while ready=0, required 0", c, rd_en);
         end
         s_stall = pkt_valid & ~ready;
         s_data  = pkt_data;
         s_sop   = pkt_sop;
         s_eop   = pkt_eop;
      end
      ready  = 1'b1;
      pkt_en = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (n_log - base !== PW || pops - p0 !== PL) begin
         n_err++;
         $display("FAIL bp_count: words=%0d pops=%0d, required %0d %0d", n_log - base,
                  pops - p0, PW, PL);
      end
      for (int k = 0; k < PW; k++) begin
         n_cmp++;
         if (log_data[base+k] !== exp_d[k] || log_eop[base+k] !== (k == PW-1)) begin
            n_err++;
            $display("FAIL bp_word%0d: data=%h eop=%b, required %h %b", k,
                     log_data[base+k], log_eop[base+k], exp_d[k], k == PW-1);
         end
      end
   endtask

   task automatic test_trailer;
      int base, waited;
      base = n_log;
      set_expect(32'hA55A0003, 32'hFFFFFFFF, 32'h2, 32'h1, 32'h1);
      pkt_en = 1'b1;
      push(32'hFFFFFFFF); push(32'h2); push(32'h1); push(32'h1);
      wait_log(base + PW, "trailer", waited);
      pkt_en = 1'b0;
      for (int k = 1; k < PW; k++) begin
         n_cmp++;
         if (log_data[base+k] !== exp_d[k] || log_eop[base+k] !== (k == PW-1)) begin
            n_err++;
            $display("FAIL trailer_word%0d: data=%h eop=%b, required %h %b", k,
                     log_data[base+k], log_eop[base+k], exp_d[k], k == PW-1);
         end
      end
`ifdef AUDIO_PKT_CHECKSUM_EN
      n_cmp++;
      if (log_data[base+5] !== 32'h00000003) begin
         n_err++;
         $display("FAIL checksum: trailer=%h, required 00000003", log_data[base+5]);
      end
`endif
      @(negedge clk);
   endtask

   task automatic test_seq_wrap_reset;
      int base, waited;
      force dut.seq_q = 16'hFFFF;
      @(negedge clk);
      release dut.seq_q;
      @(negedge clk);
      base = n_log;
      set_expect(32'hA55AFFFF, 32'h31, 32'h32, 32'h33, 32'h34);
      pkt_en = 1'b1;
      push(32'h31); push(32'h32); push(32'h33); push(32'h34);
      wait_log(base + PW, "wrap", waited);
      n_cmp++;
      if (log_data[base] !== exp_d[0] || pkt_seq !== 16'h0000) begin
         n_err++;
         $display("FAIL seq_wrap: hdr=%h seq=%h, required a55affff 0000", log_data[base], pkt_seq);
      end
      @(negedge clk);
      push(32'h51); push(32'h52); push(32'h53); push(32'h54);
      for (int c = 0; c < 20 && !(pkt_valid && pkt_data === 32'h52); c++) @(negedge clk);
      rst    = 1'b1;
      pkt_en = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (pkt_valid !== 1'b0 || pkt_seq !== 16'h0 || level !== 11'd2 || fifo_rd_data !== 32'h53) begin
         n_err++;
         $display("FAIL mid_reset: valid=%b seq=%h level=%0d head=%h, required 0 0000 2 00000053",
                  pkt_valid, pkt_seq, level, fifo_rd_data);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_pkt_en_low;
      int base, waited;
      base = n_log;
      set_expect(32'hA55A0000, 32'h53, 32'h54, 32'h61, 32'h62);
      push(32'h61); push(32'h62); push(32'h71); push(32'h72); push(32'h73); push(32'h74);
      pkt_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      pkt_en = 1'b0;
      wait_log(base + PW, "en_low", waited);
      for (int k = 0; k < PW; k++) begin
         n_cmp++;
         if (log_data[base+k] !== exp_d[k] || log_eop[base+k] !== (k == PW-1)) begin
            n_err++;
            $display("FAIL en_low_word%0d: data=%h eop=%b, required %h %b", k,
                     log_data[base+k], log_eop[base+k], exp_d[k], k == PW-1);
         end
      end
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         n_cmp++;
         if (pkt_valid !== 1'b0 || level !== 11'd4) begin
            n_err++;
            $display("FAIL en_low_idle cycle %0d: valid=%b level=%0d, required 0 4", c,
                     pkt_valid, level);
         end
      end
      n_cmp++;
      if (pkt_seq !== 16'h1 || underrun !== 1'b0) begin
         n_err++;
         $display("FAIL en_low_end: seq=%h underrun=%b, required 0001 0", pkt_seq, underrun);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_below_threshold();
      test_backpressure();
      test_trailer();
      test_seq_wrap_reset();
      test_pkt_en_low();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
